// File: rtl/trap_sequencer.sv
// Interrupt-entry and mret sequencer sitting between the ID stage and the machine CSR file.
// Optional vectored handler dispatch is enabled by defining TRAP_VECTORED_EN.
module trap_sequencer #(
  parameter int DRAIN_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic [31:0] mip,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_mret,
  input  logic        fpu_busy,
  output logic        hold_fetch,
  output logic        flush,
  output logic        trap_set,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic        intr_ack,
  output logic        mret,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        drain_err
);

  localparam int          CNT_W     = $clog2(DRAIN_MAX + 1);
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TRAP,
    S_REDIRECT,
    S_MRET
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_q, hold_d;
  logic               flush_q, flush_d;
  logic               trap_set_q, trap_set_d;
  logic [31:0]        trap_cause_q, trap_cause_d;
  logic [31:0]        trap_pc_q, trap_pc_d;
  logic               intr_ack_q, intr_ack_d;
  logic               mret_q, mret_d;
  logic               pc_redirect_q, pc_redirect_d;
  logic [31:0]        pc_target_q, pc_target_d;
  logic               drain_err_q, drain_err_d;

  logic [31:0] irq;
  logic        pend;
  logic [31:0] pend_cause;
  logic [31:0] handler;
  logic [31:0] tvec_base;

  assign irq        = mie & mip & 32'h0000_0888;
  assign pend       = mstatus_mie & (|irq);
  assign pend_cause = irq[11] ? CAUSE_MEI : (irq[3] ? CAUSE_MSI : CAUSE_MTI);
  assign tvec_base  = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode spaces handlers one word apart, indexed by the cause number.
  assign handler = (mtvec[1:0] == 2'b01) ?
                   (tvec_base + {25'd0, cause_q[4:0], 2'b00}) : tvec_base;
`else
  logic unused_tvec_mode;
  assign unused_tvec_mode = ^mtvec[1:0];
  assign handler = tvec_base;
`endif

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    cnt_d         = '0;
    hold_d        = 1'b0;
    flush_d       = 1'b0;
    trap_set_d    = 1'b0;
    trap_cause_d  = 32'd0;
    trap_pc_d     = 32'd0;
    intr_ack_d    = 1'b0;
    mret_d        = 1'b0;
    pc_redirect_d = 1'b0;
    pc_target_d   = 32'd0;
    drain_err_d   = drain_err_q;

    unique case (state_q)
      S_IDLE: begin
        // A pending interrupt wins over an mret at the same boundary; the mret re-executes on return.
        if (pend && id_valid) begin
          cause_d = pend_cause;
          epc_d   = id_pc;
          hold_d  = 1'b1;
          state_d = S_DRAIN;
        end else if (id_mret && id_valid) begin
          mret_d        = 1'b1;
          pc_redirect_d = 1'b1;
          pc_target_d   = mepc;
          flush_d       = 1'b1;
          state_d       = S_MRET;
        end
      end
      S_DRAIN: begin
        hold_d = 1'b1;
        if (fpu_busy) begin
          cnt_d = (int'(cnt_q) >= DRAIN_MAX) ? cnt_q : cnt_q + 1'b1;
          if (int'(cnt_q) + 1 >= DRAIN_MAX) begin
            drain_err_d = 1'b1;
          end
        end else begin
          trap_set_d   = 1'b1;
          trap_cause_d = cause_q;
          trap_pc_d    = epc_q;
          intr_ack_d   = (cause_q == CAUSE_MEI);
          flush_d      = 1'b1;
          state_d      = S_TRAP;
        end
      end
      S_TRAP: begin
        hold_d        = 1'b1;
        pc_redirect_d = 1'b1;
        pc_target_d   = handler;
        flush_d       = 1'b1;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: state_d = S_IDLE;
      S_MRET:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Every strobe is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cause_q       <= 32'd0;
      epc_q         <= 32'd0;
      cnt_q         <= '0;
      hold_q        <= 1'b0;
      flush_q       <= 1'b0;
      trap_set_q    <= 1'b0;
      trap_cause_q  <= 32'd0;
      trap_pc_q     <= 32'd0;
      intr_ack_q    <= 1'b0;
      mret_q        <= 1'b0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= 32'd0;
      drain_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      flush_q       <= flush_d;
      trap_set_q    <= trap_set_d;
      trap_cause_q  <= trap_cause_d;
      trap_pc_q     <= trap_pc_d;
      intr_ack_q    <= intr_ack_d;
      mret_q        <= mret_d;
      pc_redirect_q <= pc_redirect_d;
      pc_target_q   <= pc_target_d;
      drain_err_q   <= drain_err_d;
    end
  end

  // The boundary cycle itself must already stall fetch, before DRAIN is registered.
  assign hold_fetch  = hold_q | ((state_q == S_IDLE) & pend & id_valid);
  assign flush       = flush_q;
  assign trap_set    = trap_set_q;
  assign trap_cause  = trap_cause_q;
  assign trap_pc     = trap_pc_q;
  assign intr_ack    = intr_ack_q;
  assign mret        = mret_q;
  assign pc_redirect = pc_redirect_q;
  assign pc_target   = pc_target_q;
  assign drain_err   = drain_err_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized self-checking bench for trap_sequencer; predicts a per-cycle event timeline from the trap rules.
module tb_trap_sequencer;

  localparam int DM = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic [31:0] mie = '0, mip = '0, mtvec = '0, mepc = '0, id_pc = '0;
  logic        id_valid = 1'b0, id_mret = 1'b0, fpu_busy = 1'b0;
  logic        hold_fetch, flush, trap_set, intr_ack, mret, pc_redirect, drain_err;
  logic [31:0] trap_cause, trap_pc, pc_target;

  int total = 0;
  int bad   = 0;
  logic err_exp = 1'b0;

  trap_sequencer #(.DRAIN_MAX(DM)) dut (
    .clk(clk), .reset(reset), .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip),
    .mtvec(mtvec), .mepc(mepc), .id_valid(id_valid), .id_pc(id_pc), .id_mret(id_mret),
    .fpu_busy(fpu_busy), .hold_fetch(hold_fetch), .flush(flush), .trap_set(trap_set),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .intr_ack(intr_ack), .mret(mret),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .drain_err(drain_err)
  );

  always #5 clk = ~clk;

  // Reference: which trap (if any) a given CSR snapshot requests, and where it lands.
  function automatic logic [31:0] ref_cause(input logic [31:0] en, input logic [31:0] pd);
    if (en[11] && pd[11]) return 32'h8000_000B;
    if (en[3] && pd[3])   return 32'h8000_0003;
    if (en[7] && pd[7])   return 32'h8000_0007;
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_handler(input logic [31:0] tv, input logic [31:0] cs);
    logic [31:0] base;
    base = tv - (tv % 4);
`ifdef TRAP_VECTORED_EN
    if (tv % 4 == 1) return base + 4 * (cs % 32);
`endif
    return base;
  endfunction

  task automatic run_txn(input logic gie, input logic [31:0] en, input logic [31:0] pd,
                         input logic [31:0] pc, input logic [31:0] tv, input logic [31:0] epc,
                         input logic mr, input int b, input logic perturb, input string nm);
    logic [31:0] cs, hd, e_cause, e_pc, e_tgt;
    logic        pend;
    logic [6:0]  e_vec, a_vec;
    int          t;
    cs   = ref_cause(en, pd);
    pend = gie && (cs != 0);
    hd   = ref_handler(tv, cs);
    t    = b + 2;
    @(negedge clk);
    mstatus_mie = gie; mie = en; mip = pd; id_pc = pc; mtvec = tv; mepc = epc;
    id_mret = mr; id_valid = 1'b1; fpu_busy = 1'b0;
    #1;
    total++;
    if (hold_fetch !== pend) begin
      bad++;
      $display("FAIL %s boundary hold_fetch got=%b exp=%b", nm, hold_fetch, pend);
    end
    for (int c = 1; c <= b + 5; c++) begin
      @(negedge clk);
      id_valid = 1'b0; id_mret = 1'b0;
      fpu_busy = pend && (c <= b);
      if (perturb) begin
        mip = $urandom;
        mie = $urandom;
      end
      #1;
      e_vec = '0; e_cause = '0; e_pc = '0; e_tgt = '0;
      if (pend) begin
        if (b >= DM && c >= DM + 1) err_exp = 1'b1;
        // e_vec = {hold, flush, trap_set, intr_ack, mret, pc_redirect}
        e_vec[6] = (c <= t + 1);
        e_vec[5] = (c == t) || (c == t + 1);
        e_vec[4] = (c == t);
        e_vec[3] = (c == t) && (cs == 32'h8000_000B);
        e_vec[1] = (c == t + 1);
        if (c == t) begin e_cause = cs; e_pc = pc; end
        if (c == t + 1) e_tgt = hd;
      end else if (mr && c == 1) begin
        e_vec[5] = 1'b1; e_vec[2] = 1'b1; e_vec[1] = 1'b1;
        e_tgt = epc;
      end
      e_vec[0] = err_exp;
      a_vec = {hold_fetch, flush, trap_set, intr_ack, mret, pc_redirect, drain_err};
      total++;
      if (a_vec !== e_vec) begin
        bad++;
        $display("FAIL %s cyc=%0d strobes{hold,flush,tset,ack,mret,redir,derr} got=%b exp=%b",
                 nm, c, a_vec, e_vec);
      end
      total++;
      if (trap_cause !== e_cause || trap_pc !== e_pc) begin
        bad++;
        $display("FAIL %s cyc=%0d cause/pc got=%h/%h exp=%h/%h", nm, c, trap_cause, trap_pc,
                 e_cause, e_pc);
      end
      total++;
      if (pc_target !== e_tgt) begin
        bad++;
        $display("FAIL %s cyc=%0d pc_target got=%h exp=%h", nm, c, pc_target, e_tgt);
      end
    end
    mip = '0; mie = '0; fpu_busy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; id_valid = 1'b0; id_mret = 1'b0; fpu_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({hold_fetch, flush, trap_set, intr_ack, mret, pc_redirect, drain_err} !== 7'd0 ||
        trap_cause !== 0 || trap_pc !== 0 || pc_target !== 0) begin
      bad++;
      $display("FAIL reset outputs got strobes=%b cause=%h pc=%h tgt=%h exp all zero",
               {hold_fetch, flush, trap_set, intr_ack, mret, pc_redirect, drain_err},
               trap_cause, trap_pc, pc_target);
    end
    err_exp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_mei();
    run_txn(1, 32'h800, 32'h800, 32'h100, 32'h1000, 32'h0, 0, 0, 0, "basic_mei");
  endtask

  task automatic test_fpu_drain();
    run_txn(1, 32'h800, 32'h800, 32'h140, 32'h2000, 32'h0, 0, 5, 0, "drain5");
    run_txn(1, 32'h800, 32'h800, 32'h180, 32'h2000, 32'h0, 0, 10, 1, "drain_err");
    run_txn(1, 32'h8, 32'h8, 32'h1c0, 32'h2000, 32'h0, 0, 1, 0, "drain_err_sticky");
    test_reset();
  endtask

  task automatic test_priority();
    run_txn(1, 32'h888, 32'h888, 32'h300, 32'h4000, 32'h0, 0, 0, 0, "prio_all");
    run_txn(1, 32'h888, 32'h088, 32'h304, 32'h4000, 32'h0, 0, 0, 0, "prio_msi");
    run_txn(1, 32'h080, 32'h880, 32'h308, 32'h4000, 32'h0, 0, 0, 0, "prio_mti");
    run_txn(0, 32'h888, 32'h888, 32'h30c, 32'h4000, 32'h0, 0, 0, 0, "gie_off");
  endtask

  task automatic test_mret();
    run_txn(1, 32'h0, 32'h888, 32'h400, 32'h4000, 32'h200, 1, 0, 0, "mret");
    run_txn(1, 32'h800, 32'h800, 32'h404, 32'h4000, 32'h200, 1, 0, 0, "mret_vs_pend");
  endtask

  task automatic test_vectored();
    run_txn(1, 32'h80, 32'h80, 32'h500, 32'h1001, 32'h0, 0, 0, 0, "vectored_mti");
    run_txn(1, 32'h800, 32'h800, 32'h504, 32'h1001, 32'h0, 0, 0, 0, "vectored_mei");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mstatus_mie = 1'b0; mie = 32'h80; mip = 32'h80; mtvec = 32'h1000; mepc = 32'h200;
    id_pc = 32'h600; id_mret = 1'b1; id_valid = 1'b1;
    @(negedge clk);
    mstatus_mie = 1'b1; id_mret = 1'b0; id_pc = 32'h200;
    #1;
    total++;
    if (mret !== 1'b1 || pc_target !== 32'h200) begin
      bad++;
      $display("FAIL b2b mret got mret=%b tgt=%h exp 1/00000200", mret, pc_target);
    end
    @(negedge clk);
    #1;
    total++;
    if (hold_fetch !== 1'b1 || mret !== 1'b0) begin
      bad++;
      $display("FAIL b2b take got hold=%b mret=%b exp 1/0", hold_fetch, mret);
    end
    @(negedge clk);
    id_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (trap_set !== 1'b1 || trap_cause !== 32'h8000_0007 || trap_pc !== 32'h200 || intr_ack !== 1'b0) begin
      bad++;
      $display("FAIL b2b trap got set=%b cause=%h pc=%h ack=%b exp 1/80000007/00000200/0",
               trap_set, trap_cause, trap_pc, intr_ack);
    end
    @(negedge clk);
    #1;
    total++;
    if (pc_redirect !== 1'b1 || pc_target !== 32'h1000) begin
      bad++;
      $display("FAIL b2b redirect got %b/%h exp 1/00001000", pc_redirect, pc_target);
    end
    mip = '0; mie = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    @(negedge clk);
    mstatus_mie = 1'b1; mie = 32'h800; mip = 32'h800; id_pc = 32'h700; mtvec = 32'h3000;
    id_valid = 1'b1;
    @(negedge clk);
    id_valid = 1'b0; fpu_busy = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({hold_fetch, flush, trap_set, intr_ack, mret, pc_redirect, drain_err} !== 7'd0 ||
        trap_cause !== 0 || trap_pc !== 0 || pc_target !== 0) begin
      bad++;
      $display("FAIL reset_in_drain outputs got strobes=%b exp 0000000",
               {hold_fetch, flush, trap_set, intr_ack, mret, pc_redirect, drain_err});
    end
    err_exp = 1'b0;
    @(negedge clk);
    reset = 1'b1; fpu_busy = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (trap_set || pc_redirect || hold_fetch) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_in_drain aftermath got active_cycles=%0d exp 0", seen);
    end
    mip = '0; mie = '0;
  endtask

  task automatic test_random();
    logic [31:0] tv;
    for (int i = 0; i < 40; i++) begin
      tv = $urandom & 32'hFFFF_FFFD;
      run_txn(($urandom_range(0, 3) != 0), $urandom,
              $urandom & (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'hFFFF_F777),
              $urandom, tv, $urandom, ($urandom_range(0, 2) == 0),
              $urandom_range(0, 3), ($urandom_range(0, 1) != 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_mei();
    test_fpu_drain();
    test_priority();
    test_mret();
    test_vectored();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
